// File: rtl/nco_pkg.sv
// Shared constants for the three-phase NCO.
//  ACC_W / ADDR_W : accumulator and LUT address widths
//  OFF_120/OFF_240: phase offsets of 1/3 and 2/3 of a turn (2^32/3 rounded)
//  LFSR_SEED/TAPS : dither generator seed and Galois mask (taps 16,14,13,11)
package nco_pkg;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 15;

    localparam logic [ACC_W-1:0] OFF_120   = 32'h5555_5555;
    localparam logic [ACC_W-1:0] OFF_240   = 32'hAAAA_AAAB;
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    // LUT address is the top ADDR_W bits of a phase value.
    function automatic logic [ADDR_W-1:0] phase_to_addr(input logic [ACC_W-1:0] p);
        return p[ACC_W-1 -: ADDR_W];
    endfunction
endpackage

// File: rtl/nco_lfsr16.sv
// 16-bit Galois LFSR used as phase dither source.
// Ports: clk, rst_n (async active-low, loads LFSR_SEED), en (advance), q (state).
module nco_lfsr16
    import nco_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);
    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= LFSR_SEED;
        else if (en)
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
    end

    assign q = r_q;
endmodule

// File: rtl/three_phase_nco.sv
// Three-phase NCO: 32-bit phase accumulator feeding three LUT addresses spaced
// 0/120/240 degrees. Tuning words arrive on a valid/ready handshake and are
// held in a shadow register until a safe point (wrap, clear, idle, or a
// stalled zero word), so frequency changes never glitch mid-cycle.
// Optional: define PHASE_DITHER_EN to add LFSR dither below the address LSB.
// Ports:
//  clk, rst_n            clock, async active-low reset
//  en, sync_clr          accumulate enable, synchronous phase clear
//  fcw_in/valid/ready    tuning-word handshake
//  address1..3           registered LUT addresses (0/120/240 deg)
//  addr_valid            addresses come from a running accumulator
//  wrap                  pulse aligned with the first address set after carry-out
module three_phase_nco
    import nco_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic [ACC_W-1:0]  fcw_in,
    input  logic              fcw_valid,
    output logic              fcw_ready,
    output logic [ADDR_W-1:0] address1,
    output logic [ADDR_W-1:0] address2,
    output logic [ADDR_W-1:0] address3,
    output logic              addr_valid,
    output logic              wrap
);
    logic [ACC_W-1:0]  r_acc, r_fcw_active, r_fcw_shadow;
    logic              r_pending, r_carry_d, r_wrap, r_addr_valid;
    logic [ADDR_W-1:0] r_addr1, r_addr2, r_addr3;

    logic [ACC_W:0]    w_sum;
    logic              w_carry, w_xfer, w_apply;
    logic [ACC_W-1:0]  w_phase;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_fcw_active};
    assign w_carry = en & w_sum[ACC_W];
    assign w_xfer  = fcw_valid & ~r_pending;
    // A zero active word never carries, so it must not block the update.
    assign w_apply = r_pending & (w_carry | sync_clr | ~en | (r_fcw_active == '0));

`ifdef PHASE_DITHER_EN
    logic [15:0] w_dither;

    nco_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .q     (w_dither)
    );

    // Dither sits entirely below the address LSB: at most +1 on any address.
    assign w_phase = r_acc + {{(ACC_W-16){1'b0}}, w_dither};
`else
    assign w_phase = r_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_fcw_active <= '0;
            r_fcw_shadow <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (sync_clr)
                r_acc <= '0;
            else if (en)
                r_acc <= w_sum[ACC_W-1:0];

            if (w_xfer) begin
                r_fcw_shadow <= fcw_in;
                r_pending    <= 1'b1;
            end else if (w_apply) begin
                r_fcw_active <= r_fcw_shadow;
                r_pending    <= 1'b0;
            end
        end
    end

    // Addresses show acc one cycle late, so the carry is delayed once more to
    // land on the first address set computed from the wrapped accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr1      <= '0;
            r_addr2      <= '0;
            r_addr3      <= '0;
            r_addr_valid <= 1'b0;
            r_carry_d    <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_addr1      <= phase_to_addr(w_phase);
            r_addr2      <= phase_to_addr(w_phase + OFF_120);
            r_addr3      <= phase_to_addr(w_phase + OFF_240);
            r_addr_valid <= en;
            r_carry_d    <= w_carry & ~sync_clr;
            r_wrap       <= r_carry_d;
        end
    end

    assign fcw_ready  = ~r_pending;
    assign address1   = r_addr1;
    assign address2   = r_addr2;
    assign address3   = r_addr3;
    assign addr_valid = r_addr_valid;
    assign wrap       = r_wrap;
endmodule

// File: tb/tb_three_phase_nco.sv
module tb_three_phase_nco;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, sync_clr = 1'b0, fcw_valid = 1'b0;
    logic [31:0] fcw_in = '0;
    logic        fcw_ready, addr_valid, wrap;
    logic [14:0] address1, address2, address3;

    three_phase_nco dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .fcw_in(fcw_in), .fcw_valid(fcw_valid), .fcw_ready(fcw_ready),
        .address1(address1), .address2(address2), .address3(address3),
        .addr_valid(addr_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] a1, a2, a3;
        logic        v, w, r;
    } out_t;

    typedef struct {
        logic        en, clr, valid;
        logic [31:0] fcw;
        logic [14:0] a1;
        logic        w, r;
    } vec_t;

    out_t        q_exp[$];
    logic [14:0] q_und[$];
    int          checks = 0, failures = 0;

    logic [31:0] m_acc, m_act, m_sh;
    logic        m_pend, m_wd;
    logic [15:0] m_lfsr;
    out_t        m_out;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Tolerates the +1 LSB that dither may add.
    function automatic logic [14:0] undither(input logic [14:0] got, input logic [14:0] e);
`ifdef PHASE_DITHER_EN
        return (got == e + 15'd1) ? e : got;
`else
        if (got == e) return got;
        return got;
`endif
    endfunction

    task automatic model_reset();
        m_acc = '0; m_act = '0; m_sh = '0; m_pend = 1'b0; m_wd = 1'b0;
        m_lfsr = 16'hACE1;
        m_out = '{a1: 15'd0, a2: 15'd0, a3: 15'd0, v: 1'b0, w: 1'b0, r: 1'b1};
        q_exp.delete();
        q_und.delete();
    endtask

    task automatic model_step(input logic e, input logic c, input logic v, input logic [31:0] f);
        logic [32:0] s;
        logic        cy, xfer, apply;
        logic [31:0] base, p2, p3;
        s     = {1'b0, m_acc} + {1'b0, m_act};
        cy    = e && s[32];
        xfer  = v && !m_pend;
        apply = m_pend && (cy || c || !e || m_act == 32'd0);
        base  = m_acc;
        q_und.push_back(base[31:17]);
`ifdef PHASE_DITHER_EN
        base = base + {16'd0, m_lfsr};
`endif
        p2 = base + 32'h5555_5555;
        p3 = base + 32'hAAAA_AAAB;
        m_out.a1 = base[31:17];
        m_out.a2 = p2[31:17];
        m_out.a3 = p3[31:17];
        m_out.v  = e;
        m_out.w  = m_wd;
        m_wd     = cy && !c;
        m_acc    = c ? 32'd0 : (e ? s[31:0] : m_acc);
        if (apply) m_act = m_sh;
        if (xfer) m_sh = f;
        m_pend   = xfer ? 1'b1 : (apply ? 1'b0 : m_pend);
        m_out.r  = !m_pend;
`ifdef PHASE_DITHER_EN
        if (e) m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`endif
        q_exp.push_back(m_out);
    endtask

    // One clock: drive at negedge, predict, compare at the following negedge.
    task automatic cyc(input logic e, input logic c, input logic v, input logic [31:0] f);
        out_t        exp;
        logic [14:0] und;
        en = e; sync_clr = c; fcw_valid = v; fcw_in = f;
        model_step(e, c, v, f);
        @(posedge clk);
        @(negedge clk);
        if (q_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty no expected entry at %0t", $time);
        end else begin
            exp = q_exp.pop_front();
            und = q_und.pop_front();
            check("sb_outputs", {address1, address2, address3, addr_valid, wrap, fcw_ready}, exp);
`ifdef PHASE_DITHER_EN
            check("dither_bound", undither(address1, und), und);
            check("lfsr_seq", dut.u_lfsr.q, m_lfsr);
`else
            if (und != exp.a1) begin
                checks++; failures++;
                $display("FAIL model_undither got=%h expected=%h", exp.a1, und);
            end
`endif
        end
    endtask

    vec_t tbl[18];
    int   wraps;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h4000_0000, 15'd0,     1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         15'd0,     1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd0,     1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd8192,  1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd16384, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd24576, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd0,     1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h2000_0000, 15'd8192,  1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h1234_0000, 15'd16384, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd24576, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd0,     1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd4096,  1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd8192,  1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h0002_0000, 15'd12288, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h0,         15'd16384, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd0,     1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd1,     1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,         15'd2,     1'b0, 1'b1};

        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", {address1, address2, address3, addr_valid, wrap, fcw_ready},
              {45'd0, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b1;

        // Wrap timing, deferred update, clear, slow run.
        foreach (tbl[i]) begin
            cyc(tbl[i].en, tbl[i].clr, tbl[i].valid, tbl[i].fcw);
            check($sformatf("tbl%0d_a1", i), undither(address1, tbl[i].a1), tbl[i].a1);
            check($sformatf("tbl%0d_wrap", i), wrap, tbl[i].w);
            check($sformatf("tbl%0d_ready", i), fcw_ready, tbl[i].r);
        end

        // Reset asserted mid-cycle with a word pending: shadow is discarded.
        cyc(1'b1, 1'b0, 1'b1, 32'h8000_0000);
        check("pending_before_reset", fcw_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_addr", {address1, address2, address3}, 45'd0);
        check("midrun_reset_flags", {addr_valid, wrap, fcw_ready}, 3'b001);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("discarded_word_addr", address1, 15'd0);

        // Half-turn word: wraps every second cycle.
        cyc(1'b0, 1'b0, 1'b1, 32'h8000_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        wraps = 0;
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            if (wrap) wraps++;
        end
        check("half_turn_wraps", wraps, 4);

        // All-ones word: steps back 1 LSB, wraps nearly every cycle.
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        wraps = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            if (wrap) wraps++;
        end
        // Clear puts acc at 0: first step has no carry, the next 7 do; wrap
        // trails carry by two edges, so 6 of them show inside this window.
        check("all_ones_wraps", wraps, 6);

        // Random traffic against the scoreboard.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 1) == 0) ? $urandom() : {$urandom_range(0, 255), 16'h0000});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
